// File: rtl/smc_seq.sv
// smc_seq: six-beat transistor frame sequencer.
// Each beat computes a drain current (id) and transconductance (gm) term,
// inserts both into descending 6-entry lists, and after the sixth beat a
// weighted or plain sum of three list entries is strobed out two cycles later.
// Optional feature: define SMC_ABORT_ERR_EN to add an 'err' output that
// pulses for one cycle after a frame is cut short.
module smc_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [2:0] W,
   input  logic [2:0] V_GS,
   input  logic [2:0] V_DS,
   input  logic [1:0] mode,
   output logic       out_valid,
   output logic [9:0] out_n
`ifdef SMC_ABORT_ERR_EN
   ,
   output logic       err
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

   state_t          state, state_n;
   logic            start, load_en, abort;
   logic [2:0]      cnt;
   logic [1:0]      mode_r;
   logic [5:0][6:0] id_l, gm_l;
   logic [9:0]      wx, vx, dx, prod, gprod;
   logic [6:0]      id_val, gm_val;
   logic [5:0][6:0] lst;
   logic [9:0]      a, b, c, res;

   // Insert x into a descending list, dropping the smallest entry.
   function automatic logic [5:0][6:0] ins(input logic [5:0][6:0] l, input logic [6:0] x);
      logic [5:0][6:0] r;
      r[0] = (l[0] >= x) ? l[0] : x;
      for (int i = 1; i < 6; i++) begin
         if (l[i] >= x)        r[i] = l[i];
         else if (l[i-1] >= x) r[i] = x;
         else                  r[i] = l[i-1];
      end
      return r;
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state and beat-control decode.
   always_comb begin
      state_n = state;
      start   = 1'b0;
      load_en = 1'b0;
      abort   = 1'b0;
      case (state)
         IDLE: if (in_valid) begin
            start   = 1'b1;
            state_n = LOAD;
         end
         LOAD: if (!in_valid) begin
            abort   = 1'b1;
            state_n = IDLE;
         end else begin
            load_en = 1'b1;
            if (cnt == 3'd5) state_n = CALC;
         end
         CALC:    state_n = OUT;
         OUT:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Per-beat device terms; v = V_GS-1, triode when v exceeds V_DS.
   // V_GS = 0 is forced to zero so the wrapped v never reaches the math.
   always_comb begin
      wx     = 10'(W);
      vx     = 10'(V_GS) - 10'd1;
      dx     = 10'(V_DS);
      prod   = '0;
      gprod  = '0;
      id_val = '0;
      gm_val = '0;
      if (V_GS != 3'd0) begin
         if (vx > dx) begin
            prod  = wx * (10'd2 * vx * dx - dx * dx);
            gprod = 10'd2 * wx * dx;
         end else begin
            prod  = wx * vx * vx;
            gprod = 10'd2 * wx * vx;
         end
         id_val = 7'(prod / 10'd3);
         gm_val = 7'(gprod / 10'd3);
      end
   end

   // Beat counter, frame mode and sorted lists; beat 1 inserts into an empty list.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         mode_r <= '0;
         id_l   <= '0;
         gm_l   <= '0;
      end else if (start) begin
         cnt    <= 3'd1;
         mode_r <= mode;
         id_l   <= ins('0, id_val);
         gm_l   <= ins('0, gm_val);
      end else if (load_en) begin
         cnt    <= cnt + 3'd1;
         id_l   <= ins(id_l, id_val);
         gm_l   <= ins(gm_l, gm_val);
      end else if (abort) begin
         cnt    <= '0;
      end
   end

   // Result select: weighted id sum or plain gm sum, upper or lower half.
   always_comb begin
      lst = mode_r[0] ? id_l : gm_l;
      if (mode_r[1]) begin
         a = 10'(lst[0]);
         b = 10'(lst[1]);
         c = 10'(lst[2]);
      end else begin
         a = 10'(lst[3]);
         b = 10'(lst[4]);
         c = 10'(lst[5]);
      end
      res = mode_r[0] ? (10'd3 * a + 10'd4 * b + 10'd5 * c) : (a + b + c);
   end

   // Output strobe registered in CALC so it is visible during OUT only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_n     <= '0;
      end else begin
         out_valid <= (state == CALC);
         out_n     <= (state == CALC) ? res : 10'd0;
      end
   end

`ifdef SMC_ABORT_ERR_EN
   // One-cycle pulse following the cycle where a partial frame is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= 1'b0;
      else     err <= abort;
   end
`endif

endmodule

// File: tb/tb_smc_seq.sv
// Testbench for smc_seq: directed vector table, abort/reset sequences and
// randomized back-to-back frames checked against a per-frame reference model.
module tb_smc_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [2:0] W, V_GS, V_DS;
   logic [1:0] mode;
   logic       out_valid;
   logic [9:0] out_n;
`ifdef SMC_ABORT_ERR_EN
   logic       err;
`endif

   int checks = 0;
   int errors = 0;

   smc_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .W         (W),
      .V_GS      (V_GS),
      .V_DS      (V_DS),
      .mode      (mode),
      .out_valid (out_valid),
      .out_n     (out_n)
`ifdef SMC_ABORT_ERR_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   // Beat sets: [set][beat] = {W, V_GS, V_DS}
   int bset [4][6][3] = '{
      '{'{7,7,7}, '{7,7,7}, '{7,7,7}, '{7,7,7}, '{7,7,7}, '{7,7,7}},
      '{'{1,1,1}, '{3,4,1}, '{2,5,7}, '{7,3,2}, '{5,6,3}, '{4,2,6}},
      '{'{3,0,2}, '{7,0,7}, '{1,0,1}, '{5,0,3}, '{2,0,6}, '{4,0,4}},
      '{'{7,7,1}, '{7,7,2}, '{7,7,3}, '{7,7,4}, '{7,7,5}, '{7,7,6}}
   };

   typedef struct {
      int         set;
      logic [1:0] m;
      int         expv;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Reference: id/gm straight from the device equations, then sort and sum.
   function automatic int model(input int bw[6], input int bg[6], input int bd[6], input logic [1:0] m);
      int ids[6];
      int gms[6];
      int t, v, lo;
      for (int i = 0; i < 6; i++) begin
         v = bg[i] - 1;
         if (bg[i] == 0) begin
            ids[i] = 0; gms[i] = 0;
         end else if (v > bd[i]) begin
            ids[i] = (bw[i] * (2 * v * bd[i] - bd[i] * bd[i])) / 3;
            gms[i] = (2 * bw[i] * bd[i]) / 3;
         end else begin
            ids[i] = (bw[i] * v * v) / 3;
            gms[i] = (2 * bw[i] * v) / 3;
         end
      end
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 5 - i; j++) begin
            if (ids[j] < ids[j+1]) begin t = ids[j]; ids[j] = ids[j+1]; ids[j+1] = t; end
            if (gms[j] < gms[j+1]) begin t = gms[j]; gms[j] = gms[j+1]; gms[j+1] = t; end
         end
      lo = m[1] ? 0 : 3;
      if (m[0]) return 3 * ids[lo] + 4 * ids[lo+1] + 5 * ids[lo+2];
      return gms[lo] + gms[lo+1] + gms[lo+2];
   endfunction

   // Six beats, then CALC and OUT cycles; junk drives in_valid during CALC/OUT.
   // rst_out fires an asynchronous reset while the result is being strobed.
   task automatic run_frame(input int bw[6], input int bg[6], input int bd[6],
                            input logic [1:0] m, input int expv, input bit junk,
                            input bit rst_out, input string name);
      for (int b = 0; b < 6; b++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         W    = 3'(bw[b]);
         V_GS = 3'(bg[b]);
         V_DS = 3'(bd[b]);
         mode = (b == 0) ? m : 2'($urandom);
         @(negedge clk);
         chk({name, "_beat_valid"}, int'(out_valid), 0);
      end
      @(posedge clk); #1;
      in_valid = junk;
      W = 3'($urandom_range(1, 7)); V_GS = 3'($urandom_range(1, 7)); V_DS = 3'($urandom_range(1, 7));
      @(negedge clk);
      chk({name, "_t1_valid"}, int'(out_valid), 0);
      chk({name, "_t1_n"}, int'(out_n), 0);
      @(posedge clk); #1;
      in_valid = junk;
      @(negedge clk);
      chk({name, "_t2_valid"}, int'(out_valid), 1);
      chk({name, "_t2_n"}, int'(out_n), expv);
      if (rst_out) begin
         rst = 1'b1;
         #1;
         chk({name, "_async_rst_valid"}, int'(out_valid), 0);
         chk({name, "_async_rst_n"}, int'(out_n), 0);
         in_valid = 1'b0;
         @(negedge clk);
         rst = 1'b0;
      end
   endtask

   task automatic idle(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         chk({name, "_idle_valid"}, int'(out_valid), 0);
         chk({name, "_idle_n"}, int'(out_n), 0);
      end
   endtask

   task automatic get_set(input int s, output int bw[6], output int bg[6], output int bd[6]);
      for (int i = 0; i < 6; i++) begin
         bw[i] = bset[s][i][0]; bg[i] = bset[s][i][1]; bd[i] = bset[s][i][2];
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bw[6], bg[6], bd[6];
      int errcnt;
      int expv;
      logic [1:0] m;

      vecs[0]  = '{0, 2'd3, 1008};
      vecs[1]  = '{0, 2'd0, 84};
      vecs[2]  = '{1, 2'd3, 190};
      vecs[3]  = '{1, 2'd1, 19};
      vecs[4]  = '{1, 2'd2, 24};
      vecs[5]  = '{1, 2'd0, 4};
      vecs[6]  = '{2, 2'd3, 0};
      vecs[7]  = '{2, 2'd0, 0};
      vecs[8]  = '{3, 2'd3, 946};
      vecs[9]  = '{3, 2'd1, 498};
      vecs[10] = '{3, 2'd2, 69};
      vecs[11] = '{3, 2'd0, 27};

      rst = 1'b1; in_valid = 1'b0; W = 3'd0; V_GS = 3'd0; V_DS = 3'd0; mode = 2'd0;
      repeat (2) @(negedge clk);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_n", int'(out_n), 0);
`ifdef SMC_ABORT_ERR_EN
      chk("reset_err", int'(err), 0);
`endif
      rst = 1'b0;
      idle(2, "post_reset");

      // Directed vector table, alternating gaps and back-to-back starts.
      for (int i = 0; i < 12; i++) begin
         get_set(vecs[i].set, bw, bg, bd);
         run_frame(bw, bg, bd, vecs[i].m, vecs[i].expv, i[0], 1'b0, $sformatf("vec%0d", i));
         if (i % 3 == 2) idle(1, "vec_gap");
      end

      // Frame aborted after beat 3, then a full frame.
      get_set(1, bw, bg, bd);
      for (int b = 0; b < 3; b++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; W = 3'(bw[b]); V_GS = 3'(bg[b]); V_DS = 3'(bd[b]); mode = 2'd3;
      end
      errcnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         chk("abort_valid", int'(out_valid), 0);
         chk("abort_n", int'(out_n), 0);
`ifdef SMC_ABORT_ERR_EN
         if (err) errcnt++;
`endif
      end
`ifdef SMC_ABORT_ERR_EN
      chk("abort_err_pulses", errcnt, 1);
`endif
      run_frame(bw, bg, bd, 2'd3, 190, 1'b0, 1'b0, "after_abort");

      // Reset during beat 4, then a full frame.
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; W = 3'(bw[b]); V_GS = 3'(bg[b]); V_DS = 3'(bd[b]); mode = 2'd1;
      end
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_n", int'(out_n), 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      run_frame(bw, bg, bd, 2'd1, 19, 1'b1, 1'b0, "after_midrst");

      // Reset while the result is on the outputs, then a full frame.
      get_set(3, bw, bg, bd);
      run_frame(bw, bg, bd, 2'd3, 946, 1'b0, 1'b1, "rst_at_out");
      idle(1, "rst_at_out");
      run_frame(bw, bg, bd, 2'd2, 69, 1'b0, 1'b0, "after_outrst");

      // Randomized frames against the reference model.
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < 6; i++) begin
            bw[i] = $urandom_range(1, 7);
            bg[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
            bd[i] = $urandom_range(1, 7);
         end
         m = 2'($urandom);
         expv = model(bw, bg, bd, m);
         run_frame(bw, bg, bd, m, expv, 1'($urandom), 1'b0, $sformatf("rand%0d", f));
         if ($urandom_range(0, 3) == 0) idle(1, "rand_gap");
      end
      idle(2, "final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/smc_seq.md
SMC_SEQ -- requirements
Module: smc_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port in_valid, input, 1 bit: high while one transistor beat is presented.
REQ-005 Port W, input, 3 bits: transistor width, legal range 1..7.
REQ-006 Port V_GS, input, 3 bits: gate-source voltage, legal range 1..7.
REQ-007 Port V_DS, input, 3 bits: drain-source voltage, legal range 1..7.
REQ-008 Port mode, input, 2 bits: sampled on the first beat of a frame only.
REQ-009 Port out_valid, output, 1 bit: one-cycle result strobe.
REQ-010 Port out_n, output, 10 bits: result; 0 whenever out_valid is low.

Function
REQ-011 A frame SHALL be exactly 6 consecutive in_valid-high cycles, one transistor per beat, started by in_valid rising while in IDLE.
REQ-012 The state machine SHALL have states IDLE, LOAD, CALC and OUT.
REQ-013 IDLE->LOAD on beat 1; LOAD holds for beats 2..6; after beat 6 LOAD->CALC; CALC->OUT; OUT->IDLE.
REQ-014 Per beat, with v = V_GS-1: if v > V_DS (triode), id = floor(W*(2*v*V_DS - V_DS^2)/3) and gm = floor(2*W*V_DS/3); otherwise (saturation), id = floor(W*v^2/3) and gm = floor(2*W*v/3).
REQ-015 V_GS = 0 SHALL yield id = gm = 0.
REQ-016 id SHALL be held in 7 bits (max 84) and gm in 7 bits (max 28); intermediates SHALL be wide enough not to overflow.
REQ-017 id and gm SHALL each be kept in a 6-entry list sorted descending (d0 >= ... >= d5), updated by insertion each beat; equal values are interchangeable.
REQ-018 If mode[0]=1, out_n = 3*d0+4*d1+5*d2 of the id list when mode[1]=1, else 3*d3+4*d4+5*d5.
REQ-019 If mode[0]=0, out_n = d0+d1+d2 of the gm list when mode[1]=1, else d3+d4+d5.
REQ-020 out_n SHALL fit in 10 bits without overflow (max 1008).
REQ-021 Latency: with beat 6 at cycle t, out_valid SHALL be high in cycle t+2 for exactly one cycle.
REQ-022 If in_valid drops before beat 6, the partial frame SHALL be discarded, the FSM SHALL return to IDLE, and no out_valid SHALL follow.
REQ-023 in_valid during CALC or OUT SHALL be ignored.
REQ-024 A new frame MAY start in the cycle after OUT, i.e. the cycle after out_valid.
REQ-025 Sorted lists SHALL clear at the start of every frame.

Reset
REQ-026 Asserting rst at any time, including mid-frame, SHALL force IDLE, clear the lists and beat counter, and drive out_valid = 0 and out_n = 0 asynchronously.
REQ-027 The first frame after rst deasserts SHALL be processed normally.

Configuration
REQ-028 With macro SMC_ABORT_ERR_EN defined, the module SHALL add an output port err (1 bit, reset 0) that pulses high for one cycle in the cycle after an aborted frame (REQ-022).
REQ-029 Without SMC_ABORT_ERR_EN, the err port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-030 Six beats of W=7, V_GS=7, V_DS=7 with mode=3 -> out_n=1008; the same beats with mode=0 -> out_n=84.
REQ-031 Beats (W,V_GS,V_DS) = (1,1,1), (3,4,1), (2,5,7), (7,3,2), (5,6,3), (4,2,6) -> out_n is 190 for mode=3, 19 for mode=1, 24 for mode=2 and 4 for mode=0.
REQ-032 in_valid drops after beat 3 -> no out_valid; err pulses once when SMC_ABORT_ERR_EN is defined; a following full frame gives the correct result.
REQ-033 rst asserted at beat 4 -> out_valid=0 and out_n=0 immediately; the next frame is correct.
REQ-034 Back-to-back frames with in_valid high during CALC/OUT -> those beats are ignored, each frame gives exactly one out_valid at t+2, and out_n=0 outside out_valid.
